// File: rtl/resta_pkg.sv
// Shared types for the pipelined subtract/compare unit: opcode encoding and NZCV flag bundle.
package resta_pkg;

    typedef enum logic [1:0] {
        OP_SUB = 2'b00,
        OP_SBC = 2'b01,
        OP_CMP = 2'b10,
        OP_RSB = 2'b11
    } op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/resta_pipe_if.sv
// Operand/result handshake bundle for resta_pipe; master is the producer/consumer, slave is the unit.
interface resta_pipe_if
    import resta_pkg::*;
#(
    parameter int M = 4
);
    logic         in_valid;
    logic         in_ready;
    op_t          op;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] R;
    logic         C;
    logic         N;
    logic         V;
    logic         Z;
    logic         carry_q;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, R, C, N, V, Z, carry_q
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, R, C, N, V, Z, carry_q
    );
endinterface

// File: rtl/resta_core.sv
// Combinational M-bit X + ~Y + cin with NZCV flags; carry out of bit M means "no borrow".
module resta_core
    import resta_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    input  logic         cin,
    output logic [M-1:0] d,
    output flags_t       flags
);
    logic [M:0] sum;
    logic [M-1:0] y_inv;

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_inv
            assign y_inv[gi] = ~y[gi];
        end
    endgenerate

    assign sum = {1'b0, x} + {1'b0, y_inv} + {{M{1'b0}}, cin};
    assign d   = sum[M-1:0];

    always_comb begin
        flags   = '0;
        flags.c = sum[M];
        flags.n = sum[M-1];
        flags.z = (sum[M-1:0] == '0);
        // Overflow only when operands differ in sign and the result leaves X's sign.
        flags.v = (x[M-1] != y[M-1]) && (sum[M-1] != x[M-1]);
    end
endmodule

// File: rtl/resta_pipe.sv
// Two-stage streaming subtract/compare unit with valid/ready on both sides and a stored carry for SBC chains.
module resta_pipe
    import resta_pkg::*;
#(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    resta_pipe_if.slave  bus
);
    logic         s1_valid_reg;
    op_t          s1_op_reg;
    logic [M-1:0] s1_a_reg;
    logic [M-1:0] s1_b_reg;

    logic         s2_valid_reg;
    logic [M-1:0] r_reg;
    flags_t       flags_reg;
    logic         carry_q_reg;

    logic         adv1;
    logic         adv2;
    logic [M-1:0] core_x;
    logic [M-1:0] core_y;
    logic         core_cin;
    logic [M-1:0] core_d;
    flags_t       core_flags;

    assign adv2         = !s2_valid_reg || bus.out_ready;
    assign adv1         = !s1_valid_reg || adv2;
    assign bus.in_ready = adv1 && !rst;

    always_comb begin
        core_x   = s1_a_reg;
        core_y   = s1_b_reg;
        core_cin = 1'b1;
        case (s1_op_reg)
            OP_RSB: begin
                core_x = s1_b_reg;
                core_y = s1_a_reg;
            end
            OP_SBC:  core_cin = carry_q_reg;
            default: ;
        endcase
    end

    resta_core #(.M(M)) u_core (
        .x     (core_x),
        .y     (core_y),
        .cin   (core_cin),
        .d     (core_d),
        .flags (core_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
            r_reg        <= '0;
            flags_reg    <= '0;
            carry_q_reg  <= 1'b1;
        end else begin
            if (adv1) begin
                s1_valid_reg <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op_reg <= bus.op;
                    s1_a_reg  <= bus.A;
                    s1_b_reg  <= bus.B;
                end
            end
            if (adv2) begin
                s2_valid_reg <= s1_valid_reg;
                // carry_q follows every stage-2 load, CMP included, so SBC sees its predecessor's carry.
                if (s1_valid_reg) begin
                    r_reg       <= (s1_op_reg == OP_CMP) ? '0 : core_d;
                    flags_reg   <= core_flags;
                    carry_q_reg <= core_flags.c;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid_reg;
    assign bus.R         = r_reg;
    assign bus.C         = flags_reg.c;
    assign bus.N         = flags_reg.n;
    assign bus.V         = flags_reg.v;
    assign bus.Z         = flags_reg.z;
    assign bus.carry_q   = carry_q_reg;
endmodule

// File: tb/tb_resta_pipe.sv
// Scoreboard bench for resta_pipe (M=4): directed vectors, backpressure, mid-stream reset and random traffic.
module tb_resta_pipe;
    import resta_pkg::*;

    localparam int M = 4;

    typedef struct {
        logic [3:0] r;
        logic       c, n, v, z;
        int         cyc;
        bit         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    resta_pipe_if #(.M(M)) bus ();
    resta_pipe #(.M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   carry_m = 1'b1;

    logic       last_in_ready, last_out_valid, last_cq;
    logic [3:0] last_r;
    logic [3:0] last_nzcv;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: signed/unsigned integer subtraction with an explicit borrow.
    function automatic exp_t model(input op_t o, input int a, input int b, input bit cin);
        exp_t e;
        int x, y, bin, diff, sx, sy, sd;
        x = (o == OP_RSB) ? b : a;
        y = (o == OP_RSB) ? a : b;
        bin  = (o == OP_SBC) ? (cin ? 0 : 1) : 0;
        diff = x - y - bin;
        sx = (x >= 8) ? x - 16 : x;
        sy = (y >= 8) ? y - 16 : y;
        sd = sx - sy - bin;
        e.c = (diff >= 0);
        e.v = (sd < -8) || (sd > 7);
        e.n = (((diff % 16) + 16) % 16) >= 8;
        e.z = (((diff % 16) + 16) % 16) == 0;
        e.r = (o == OP_CMP) ? 4'd0 : 4'((diff % 16 + 16) % 16);
        e.cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic exp_t lit(input logic [3:0] r, input bit c, input bit n, input bit v, input bit z);
        exp_t e;
        e.r = r; e.c = c; e.n = n; e.v = v; e.z = z; e.cyc = 0; e.lat = 1'b1;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus, entered and left just after a rising edge.
    task automatic drive(input bit v, input op_t o, input logic [3:0] a, input logic [3:0] b,
                         input bit ordy, input bit use_lit, input exp_t le, output bit acc);
        exp_t e;
        bus.in_valid  = v;
        bus.op        = o;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = ordy;
        @(negedge clk);
        last_in_ready  = bus.in_ready;
        last_out_valid = bus.out_valid;
        last_cq        = bus.carry_q;
        last_r         = bus.R;
        last_nzcv      = {bus.N, bus.Z, bus.C, bus.V};
        acc = v && bus.in_ready && !rst;
        if (acc) begin
            e = use_lit ? le : model(o, int'(a), int'(b), carry_m);
            e.cyc = cyc;
            carry_m = e.c;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, OP_SUB, 4'd0, 4'd0, 1'b1, 1'b0, lit(0, 0, 0, 0, 0), acc);
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks holds during stalls.
    logic       held = 1'b0;
    logic [3:0] held_r;
    logic [3:0] held_f;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!(bus.out_valid && bus.R == held_r && {bus.N, bus.Z, bus.C, bus.V} == held_f)) begin
                    errors++;
                    $display("FAIL stall_hold got v%0d R=%h nzcv=%b want v1 R=%h nzcv=%b",
                             bus.out_valid, bus.R, {bus.N, bus.Z, bus.C, bus.V}, held_r, held_f);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL beat unexpected output R=%h want no output", bus.R);
                end else begin
                    e = q.pop_front();
                    if (bus.R !== e.r || bus.C !== e.c || bus.N !== e.n || bus.V !== e.v ||
                        bus.Z !== e.z || bus.carry_q !== e.c || (e.lat && cyc != e.cyc + 2)) begin
                        errors++;
                        $display("FAIL beat got R=%h C%0d N%0d V%0d Z%0d cq%0d cyc%0d want R=%h C%0d N%0d V%0d Z%0d cq%0d cyc%0d",
                                 bus.R, bus.C, bus.N, bus.V, bus.Z, bus.carry_q, cyc,
                                 e.r, e.c, e.n, e.v, e.z, e.c, e.cyc + 2);
                    end else begin
                        $display("beat ok R=%h C%0d N%0d V%0d Z%0d cyc%0d", bus.R, bus.C, bus.N, bus.V, bus.Z, cyc);
                    end
                end
            end
            held   = bus.out_valid && !bus.out_ready;
            held_r = bus.R;
            held_f = {bus.N, bus.Z, bus.C, bus.V};
        end
    end

    initial begin
        bit acc;
        int idx, nacc, guard;
        logic [3:0] bp_a[4];
        logic [3:0] bp_b[4];

        bus.in_valid = 1'b0; bus.op = OP_SUB; bus.A = '0; bus.B = '0; bus.out_ready = 1'b1;
        #1;
        rst = 1'b1;
        drive(1'b0, OP_SUB, 4'd0, 4'd0, 1'b1, 1'b0, lit(0, 0, 0, 0, 0), acc);
        drive(1'b1, OP_SUB, 4'd3, 4'd1, 1'b1, 1'b0, lit(0, 0, 0, 0, 0), acc);
        check("rst_in_ready", int'(last_in_ready), 0);
        check("rst_out_valid", int'(last_out_valid), 0);
        check("rst_carry_q", int'(last_cq), 1);
        check("rst_r_flags", int'({last_r, last_nzcv}), 0);
        rst = 1'b0;

        // SUB sweep, back to back, exact latency
        drive(1'b1, OP_SUB, 4'b0100, 4'b0010, 1'b1, 1'b1, lit(4'b0010, 1, 0, 0, 0), acc);
        drive(1'b1, OP_SUB, 4'b0010, 4'b0100, 1'b1, 1'b1, lit(4'b1110, 0, 1, 0, 0), acc);
        drive(1'b1, OP_SUB, 4'b0001, 4'b0001, 1'b1, 1'b1, lit(4'b0000, 1, 0, 0, 1), acc);
        drive(1'b1, OP_SUB, 4'b0111, 4'b1111, 1'b1, 1'b1, lit(4'b1000, 0, 1, 1, 0), acc);
        drive(1'b1, OP_SUB, 4'b1010, 4'b0101, 1'b1, 1'b1, lit(4'b0101, 1, 0, 1, 0), acc);
        // Multi-word 0x30 - 0x11, then CMP and RSB
        drive(1'b1, OP_SUB, 4'b0000, 4'b0001, 1'b1, 1'b1, lit(4'b1111, 0, 1, 0, 0), acc);
        drive(1'b1, OP_SBC, 4'b0011, 4'b0001, 1'b1, 1'b1, lit(4'b0001, 1, 0, 0, 0), acc);
        drive(1'b1, OP_CMP, 4'b0101, 4'b0101, 1'b1, 1'b1, lit(4'b0000, 1, 0, 0, 1), acc);
        drive(1'b1, OP_RSB, 4'b0011, 4'b0101, 1'b1, 1'b1, lit(4'b0010, 1, 0, 0, 0), acc);
        idle(4);

        // Backpressure: 4 beats, consumer stalls 3 cycles after first result
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = 4'($urandom_range(0, 15));
            bp_b[i] = 4'($urandom_range(0, 15));
        end
        idx = 0;
        for (int k = 0; k < 12; k++) begin
            drive(idx < 4, OP_SUB, bp_a[idx % 4], bp_b[idx % 4], !(k >= 2 && k <= 4), 1'b0,
                  lit(0, 0, 0, 0, 0), acc);
            if (acc) idx++;
            if (k >= 2 && k <= 4) check("bp_in_ready", int'(last_in_ready), 0);
            if (k >= 5 && k <= 8) check("bp_no_gap", int'(last_out_valid), 1);
        end
        check("bp_accepted", idx, 4);
        idle(3);

        // Reset mid-stream with both stages full and carry_q = 0
        drive(1'b1, OP_SUB, 4'd0, 4'd1, 1'b1, 1'b0, lit(0, 0, 0, 0, 0), acc);
        drive(1'b1, OP_SUB, 4'd0, 4'd1, 1'b0, 1'b0, lit(0, 0, 0, 0, 0), acc);
        rst = 1'b1;
        drive(1'b0, OP_SUB, 4'd0, 4'd0, 1'b0, 1'b0, lit(0, 0, 0, 0, 0), acc);
        check("mid_rst_in_ready", int'(last_in_ready), 0);
        check("mid_rst_pre_cq", int'(last_cq), 0);
        check("mid_rst_pre_valid", int'(last_out_valid), 1);
        rst = 1'b0;
        q.delete();
        carry_m = 1'b1;
        drive(1'b1, OP_SBC, 4'b0101, 4'b0010, 1'b1, 1'b1, lit(4'b0011, 1, 0, 0, 0), acc);
        check("post_rst_out_valid", int'(last_out_valid), 0);
        check("post_rst_r_flags", int'({last_r, last_nzcv}), 0);
        check("post_rst_carry_q", int'(last_cq), 1);
        idle(4);

        // Random traffic against the reference model
        nacc = 0;
        guard = 0;
        while (nacc < 10000 && guard < 40000) begin
            drive($urandom_range(0, 3) != 0, op_t'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, 1'b0, lit(0, 0, 0, 0, 0), acc);
            if (acc) nacc++;
            guard++;
        end
        check("rand_accepted", nacc, 10000);
        idle(6);
        check("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
